// File: rtl/disp_elev_pkg.sv
// rtl/disp_elev_pkg.sv - shared display codes, FSM states and helpers for the elevator controller
// The 7-segment decoder consumes the same CODE_* constants.
package disp_elev_pkg;

   localparam int NUM_FLOORS = 3;

   localparam logic [2:0] CODE_F0   = 3'b000;
   localparam logic [2:0] CODE_F1   = 3'b001;
   localparam logic [2:0] CODE_F2   = 3'b010;
   localparam logic [2:0] CODE_UP   = 3'b011;
   localparam logic [2:0] CODE_DN   = 3'b100;
   localparam logic [2:0] CODE_STOP = 3'b111;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DOOR    = 3'd1,
      MOVE_UP = 3'd2,
      MOVE_DN = 3'd3,
      HALT    = 3'd4
   } state_e;

   function automatic logic [2:0] floor_code(input logic [1:0] f);
      case (f)
         2'd1:    return CODE_F1;
         2'd2:    return CODE_F2;
         default: return CODE_F0;
      endcase
   endfunction

   function automatic logic [2:0] floor_onehot(input logic [1:0] f);
      return 3'b001 << f;
   endfunction

endpackage

// File: rtl/disp_elev_sched.sv
// rtl/disp_elev_sched.sv - combinational travel-direction evaluator
// Direction preference: keep going up if dir is up and work lies above, else serve below, else above.
module disp_elev_sched
   import disp_elev_pkg::*;
(
   input  logic [1:0] floor_i,
   input  logic [2:0] req_i,
   input  logic       dir_i,
   output logic       go_up_o,
   output logic       go_dn_o
);

   logic above;
   logic below;

   always_comb begin
      above = 1'b0;
      below = 1'b0;
      for (int k = 0; k < NUM_FLOORS; k++) begin
         if (2'(k) > floor_i) above = above | req_i[k];
         if (2'(k) < floor_i) below = below | req_i[k];
      end
   end

   assign go_up_o = above & ((dir_i == DIR_UP) | ~below);
   assign go_dn_o = below & ~((dir_i == DIR_UP) & above);

endmodule

// File: rtl/disp_encode_elev.sv
// rtl/disp_encode_elev.sv - 3-floor elevator controller driving the registered display code
// Optional odd-parity output p enabled by defining DISP_ENC_PARITY_EN.
module disp_encode_elev
   import disp_elev_pkg::*;
#(
   parameter int TRAVEL_TICKS = 50_000_000,
   parameter int DOOR_TICKS   = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] call,
   input  logic       stop,
   output logic       o0,
   output logic       o1,
   output logic       o2
`ifdef DISP_ENC_PARITY_EN
   ,
   output logic       p
`endif
);

   localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
   localparam int TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
   localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_TICKS - 1);
   localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_TICKS - 1);

   state_e          state_q, state_d;
   logic [1:0]      floor_q, floor_d;
   logic [2:0]      req_q, req_d;
   logic            dir_q, dir_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      code_q, code_d;

   logic [2:0]      set_mask;
   logic [2:0]      req_eff;
   logic [1:0]      floor_arr;
   logic            arr_dir;
   logic            go_up, go_dn;
   logic            arr_up, arr_dn;
   logic            arr_further;
   logic            at_stop_floor;

   always_comb begin
      set_mask = '0;
      for (int k = 0; k < NUM_FLOORS; k++) begin
         set_mask[k] = call[k] & ~stop & (state_q != HALT)
                     & ~(((state_q == IDLE) | (state_q == DOOR)) & (floor_q == 2'(k)));
      end
   end

   assign req_eff   = req_q | set_mask;
   assign arr_dir   = (state_q == MOVE_UP) ? DIR_UP : DIR_DN;
   assign floor_arr = (state_q == MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;

   disp_elev_sched u_sched_cur (
      .floor_i (floor_q),
      .req_i   (req_q),
      .dir_i   (dir_q),
      .go_up_o (go_up),
      .go_dn_o (go_dn)
   );

   // Evaluated at the arrival floor with the travel direction forced, so go_* means "work further on".
   disp_elev_sched u_sched_arr (
      .floor_i (floor_arr),
      .req_i   (req_eff),
      .dir_i   (arr_dir),
      .go_up_o (arr_up),
      .go_dn_o (arr_dn)
   );

   assign arr_further   = (state_q == MOVE_UP) ? arr_up : arr_dn;
   assign at_stop_floor = |(req_eff & floor_onehot(floor_arr));

   always_comb begin
      state_d = state_q;
      floor_d = floor_q;
      req_d   = req_eff;
      dir_d   = dir_q;
      timer_d = timer_q;

      if (stop) begin
         state_d = HALT;
         timer_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (call[floor_q] | |(req_q & floor_onehot(floor_q))) begin
                  state_d = DOOR;
                  timer_d = DOOR_LOAD;
                  req_d   = req_eff & ~floor_onehot(floor_q);
               end else if (go_up) begin
                  state_d = MOVE_UP;
                  timer_d = TRAVEL_LOAD;
                  dir_d   = DIR_UP;
               end else if (go_dn) begin
                  state_d = MOVE_DN;
                  timer_d = TRAVEL_LOAD;
                  dir_d   = DIR_DN;
               end
            end
            DOOR: begin
               if (call[floor_q]) begin
                  timer_d = DOOR_LOAD;
               end else if (timer_q == '0) begin
                  state_d = IDLE;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            MOVE_UP, MOVE_DN: begin
               if (timer_q == '0) begin
                  floor_d = floor_arr;
                  if (at_stop_floor) begin
                     state_d = DOOR;
                     timer_d = DOOR_LOAD;
                     req_d   = req_eff & ~floor_onehot(floor_arr);
                  end else if (arr_further) begin
                     timer_d = TRAVEL_LOAD;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            HALT: begin
               state_d = IDLE;
               timer_d = '0;
            end
            default: begin
               state_d = IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      case (state_d)
         IDLE, DOOR: code_d = floor_code(floor_d);
         MOVE_UP:    code_d = CODE_UP;
         MOVE_DN:    code_d = CODE_DN;
         HALT:       code_d = CODE_STOP;
         default:    code_d = CODE_F0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         floor_q <= 2'd0;
         req_q   <= 3'b000;
         dir_q   <= DIR_UP;
         timer_q <= '0;
         code_q  <= CODE_F0;
      end else begin
         state_q <= state_d;
         floor_q <= floor_d;
         req_q   <= req_d;
         dir_q   <= dir_d;
         timer_q <= timer_d;
         code_q  <= code_d;
      end
   end

   assign {o2, o1, o0} = code_q;

`ifdef DISP_ENC_PARITY_EN
   logic p_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= 1'b1;
      end else begin
         p_q <= ~(^code_d);
      end
   end

   assign p = p_q;
`endif

endmodule

// File: tb/tb_disp_encode_elev.sv
// tb/tb_disp_encode_elev.sv - table-driven bench for disp_encode_elev (TRAVEL_TICKS=4, DOOR_TICKS=3)
module tb_disp_encode_elev;
   import disp_elev_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] call;
   logic       stop;
   logic       o0, o1, o2;
`ifdef DISP_ENC_PARITY_EN
   logic       p;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0] call;
      logic       stop;
      logic [2:0] code;
      state_e     st;
      logic [2:0] req;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   disp_encode_elev #(
      .TRAVEL_TICKS (4),
      .DOOR_TICKS   (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .call  (call),
      .stop  (stop),
      .o0    (o0),
      .o1    (o1),
      .o2    (o2)
`ifdef DISP_ENC_PARITY_EN
      ,
      .p     (p)
`endif
   );

   task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int idx, input logic [2:0] code,
                            input state_e st, input logic [2:0] rq);
      chk({tag, "_code"}, idx, {1'b0, o2, o1, o0}, {1'b0, code});
      chk({tag, "_state"}, idx, {1'b0, 3'(dut.state_q)}, {1'b0, 3'(st)});
      chk({tag, "_req"}, idx, {1'b0, dut.req_q}, {1'b0, rq});
`ifdef DISP_ENC_PARITY_EN
      chk({tag, "_parity"}, idx, {3'b000, p}, {3'b000, ~(^code)});
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void push(input logic [2:0] c, input logic s, input logic [2:0] code,
                                input state_e st, input logic [2:0] rq, input int n);
      vec_t v;
      v.call = c; v.stop = s; v.code = code; v.st = st; v.req = rq;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endfunction

   initial begin
      rst_n = 1'b0;
      call  = 3'b000;
      stop  = 1'b0;
      #2;
      check_all("reset", 0, 3'b000, IDLE, 3'b000);
      #10;
      rst_n = 1'b1;

      // Idle after reset
      push(3'b000, 0, 3'b000, IDLE,    3'b000, 3);
      // Floor 0 -> 2, passing floor 1
      push(3'b100, 0, 3'b000, IDLE,    3'b100, 1);
      push(3'b000, 0, 3'b011, MOVE_UP, 3'b100, 8);
      push(3'b000, 0, 3'b010, DOOR,    3'b000, 3);
      push(3'b000, 0, 3'b010, IDLE,    3'b000, 1);
      // Floor 2, calls to 0 and 1 together
      push(3'b011, 0, 3'b010, IDLE,    3'b011, 1);
      push(3'b000, 0, 3'b100, MOVE_DN, 3'b011, 4);
      push(3'b000, 0, 3'b001, DOOR,    3'b001, 3);
      push(3'b000, 0, 3'b001, IDLE,    3'b001, 1);
      push(3'b000, 0, 3'b100, MOVE_DN, 3'b001, 4);
      push(3'b000, 0, 3'b000, DOOR,    3'b000, 3);
      push(3'b000, 0, 3'b000, IDLE,    3'b000, 1);
      // Call at the current floor opens the door directly
      push(3'b001, 0, 3'b000, DOOR,    3'b000, 1);
      push(3'b000, 0, 3'b000, DOOR,    3'b000, 2);
      push(3'b000, 0, 3'b000, IDLE,    3'b000, 1);
      // Emergency stop mid-move, calls ignored while halted
      push(3'b100, 0, 3'b000, IDLE,    3'b100, 1);
      push(3'b000, 0, 3'b011, MOVE_UP, 3'b100, 2);
      push(3'b000, 1, 3'b111, HALT,    3'b100, 2);
      push(3'b010, 1, 3'b111, HALT,    3'b100, 1);
      push(3'b000, 1, 3'b111, HALT,    3'b100, 2);
      push(3'b000, 0, 3'b000, IDLE,    3'b100, 1);
      push(3'b000, 0, 3'b011, MOVE_UP, 3'b100, 8);
      push(3'b000, 0, 3'b010, DOOR,    3'b000, 3);
      push(3'b000, 0, 3'b010, IDLE,    3'b000, 1);
      // Door dwell restart at floor 1, with floor 0 pending to expose the delay
      push(3'b010, 0, 3'b010, IDLE,    3'b010, 1);
      push(3'b000, 0, 3'b100, MOVE_DN, 3'b010, 4);
      push(3'b000, 0, 3'b001, DOOR,    3'b000, 1);
      push(3'b001, 0, 3'b001, DOOR,    3'b001, 1);
      push(3'b000, 0, 3'b001, DOOR,    3'b001, 1);
      push(3'b010, 0, 3'b001, DOOR,    3'b001, 1);
      push(3'b000, 0, 3'b001, DOOR,    3'b001, 2);
      push(3'b000, 0, 3'b001, IDLE,    3'b001, 1);
      push(3'b000, 0, 3'b100, MOVE_DN, 3'b001, 4);
      push(3'b000, 0, 3'b000, DOOR,    3'b000, 3);
      push(3'b000, 0, 3'b000, IDLE,    3'b000, 1);

      foreach (vecs[i]) begin
         call = vecs[i].call;
         stop = vecs[i].stop;
         tick();
         check_all("vec", i, vecs[i].code, vecs[i].st, vecs[i].req);
      end
      call = 3'b000;
      stop = 1'b0;

      // Asynchronous reset in the middle of a move
      call = 3'b100;
      tick();
      call = 3'b000;
      tick();
      tick();
      check_all("pre_rst", 0, 3'b011, MOVE_UP, 3'b100);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 0, 3'b000, IDLE, 3'b000);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("post_rst", i, 3'b000, IDLE, 3'b000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
